// File: rtl/qcs_dyn_pre_gen_pkg.sv
// Shared types and helpers for the dynamic preamble generator blocks.
// Holds the NHTP read-sequencer state type, bandwidth codes and the subband span lookup.
package qcs_dyn_pre_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHK,
        RUN,
        DONE
    } nhtp_seq_st_t;

    localparam logic [1:0] BW_20  = 2'd0;
    localparam logic [1:0] BW_40  = 2'd1;
    localparam logic [1:0] BW_80  = 2'd2;
    localparam logic [1:0] BW_160 = 2'd3;

    localparam int SUBBAND_MAX = 8;

    // 20 MHz subbands covered by a given packet bandwidth.
    function automatic logic [SUBBAND_MAX-1:0] span_mask(input logic [1:0] bw);
        case (bw)
            BW_20:   span_mask = 8'h01;
            BW_40:   span_mask = 8'h03;
            BW_80:   span_mask = 8'h0F;
            default: span_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic [2:0] first_set(input logic [SUBBAND_MAX-1:0] mask);
        first_set = 3'd0;
        for (int i = SUBBAND_MAX - 1; i >= 0; i--) begin
            if (mask[i]) first_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/qcs_nhtp_rd_seq_if.sv
// Config, handshake and table-read bus between the TX config block, the NHTP read
// sequencer (slave side) and the preamble generator table port.
interface qcs_nhtp_rd_seq_if #(
    parameter int ADDR_DW   = 7,
    parameter int BW_W      = 2,
    parameter int SUBBAND_W = 8,
    parameter int GAMMA_W   = 16
);
    logic                 start;
    logic                 abort;
    logic [BW_W-1:0]      txconfig_bw;
    logic [BW_W-1:0]      sys_bw_mode;
    logic [SUBBAND_W-1:0] config_mu_subband_present;
    logic [GAMMA_W-1:0]   config_gamma_rotation;
    logic [3:0]           n_tx;
    logic                 rd_rdy;

    logic                 nhtp_re;
    logic [ADDR_DW-1:0]   nhtp_raddr;
    logic [2:0]           nhtp_sb_idx;
    logic [1:0]           nhtp_gamma;
    logic [3:0]           nhtp_n_tx;
    logic                 nhtp_4ch;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, abort, txconfig_bw, sys_bw_mode, config_mu_subband_present,
               config_gamma_rotation, n_tx, rd_rdy,
        input  nhtp_re, nhtp_raddr, nhtp_sb_idx, nhtp_gamma, nhtp_n_tx, nhtp_4ch,
               busy, done, err
    );

    modport slave (
        input  start, abort, txconfig_bw, sys_bw_mode, config_mu_subband_present,
               config_gamma_rotation, n_tx, rd_rdy,
        output nhtp_re, nhtp_raddr, nhtp_sb_idx, nhtp_gamma, nhtp_n_tx, nhtp_4ch,
               busy, done, err
    );

endinterface

// File: rtl/qcs_nhtp_sb_pick.sv
// Combinational next-set-bit finder: the next active subband strictly above cur_idx,
// with last=1 when no active subband remains above it.
module qcs_nhtp_sb_pick #(
    parameter int SUBBAND_W = 8,
    parameter int SB_W      = $clog2(SUBBAND_W)
) (
    input  logic [SUBBAND_W-1:0] mask,
    input  logic [SB_W-1:0]      cur_idx,
    output logic [SB_W-1:0]      next_idx,
    output logic                 last
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        next_idx = cur_idx;
        last     = 1'b1;
        for (int i = SUBBAND_W - 1; i >= 0; i--) begin
            if (i > int'(cur_idx) && mask[i]) begin
                next_idx = SB_W'(i);
                last     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/qcs_nhtp_rd_seq.sv
// NHTP table read sequencer: on start, walks L-STF then L-LTF samples over every active
// 20 MHz subband and drives the table read enable, address and per-read context.
module qcs_nhtp_rd_seq
    import qcs_dyn_pre_gen_pkg::*;
#(
    parameter int ADDR_DW   = 7,
    parameter int NUM_SMP   = 64,
    parameter int BW_W      = 2,
    parameter int SUBBAND_W = 8,
    parameter int GAMMA_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    qcs_nhtp_rd_seq_if.slave   bus
);

    localparam int SMP_W = $clog2(NUM_SMP);
    localparam int SB_W  = $clog2(SUBBAND_W);

    nhtp_seq_st_t         st;
    logic [BW_W-1:0]      bw_q;
    logic [BW_W-1:0]      sys_bw_q;
    logic [SUBBAND_W-1:0] present_q;
    logic [GAMMA_W-1:0]   gamma_q;
    logic [3:0]           n_tx_q;
    logic [SUBBAND_W-1:0] mask_q;
    logic [SB_W-1:0]      sb_first_q;
    logic [SB_W-1:0]      sb_q;
    logic                 field_q;
    logic [SMP_W-1:0]     smp_q;

    logic [SUBBAND_W-1:0] mask_w;
    logic [SB_W-1:0]      sb_next;
    logic                 sb_last;
    logic                 smp_last;

    assign mask_w   = present_q & SUBBAND_W'(span_mask(2'(bw_q)));
    assign smp_last = (smp_q == SMP_W'(NUM_SMP - 1));

    qcs_nhtp_sb_pick #(
        .SUBBAND_W (SUBBAND_W),
        .SB_W      (SB_W)
    ) u_sb_pick (
        .mask     (mask_q),
        .cur_idx  (sb_q),
        .next_idx (sb_next),
        .last     (sb_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st              <= IDLE;
            bw_q            <= '0;
            sys_bw_q        <= '0;
            present_q       <= '0;
            gamma_q         <= '0;
            n_tx_q          <= '0;
            mask_q          <= '0;
            sb_first_q      <= '0;
            sb_q            <= '0;
            field_q         <= 1'b0;
            smp_q           <= '0;
            bus.nhtp_re     <= 1'b0;
            bus.nhtp_raddr  <= '0;
            bus.nhtp_sb_idx <= '0;
            bus.nhtp_gamma  <= '0;
            bus.nhtp_n_tx   <= '0;
            bus.nhtp_4ch    <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments; the defaults make re/done/err pulses.
            bus.nhtp_re <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            case (st)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        bw_q      <= bus.txconfig_bw;
                        sys_bw_q  <= bus.sys_bw_mode;
                        present_q <= bus.config_mu_subband_present;
                        gamma_q   <= bus.config_gamma_rotation;
                        n_tx_q    <= bus.n_tx;
                        bus.busy  <= 1'b1;
                        st        <= CHK;
                    end
                end
                CHK: begin
                    bus.nhtp_n_tx <= n_tx_q;
                    bus.nhtp_4ch  <= (2'(bw_q) >= BW_80);
                    if (bus.abort) begin
                        bus.busy <= 1'b0;
                        st       <= IDLE;
                    end else if (bw_q > sys_bw_q || mask_w == '0 || n_tx_q == 4'd0) begin
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                        st       <= IDLE;
                    end else begin
                        mask_q     <= mask_w;
                        sb_first_q <= SB_W'(first_set(8'(mask_w)));
                        sb_q       <= SB_W'(first_set(8'(mask_w)));
                        field_q    <= 1'b0;
                        smp_q      <= '0;
                        st         <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        bus.busy <= 1'b0;
                        st       <= IDLE;
                    end else if (bus.rd_rdy) begin
                        bus.nhtp_re     <= 1'b1;
                        bus.nhtp_raddr  <= ADDR_DW'({field_q, smp_q});
                        bus.nhtp_sb_idx <= 3'(sb_q);
                        bus.nhtp_gamma  <= gamma_q[2*sb_q +: 2];
                        if (smp_last) begin
                            smp_q <= '0;
                            // Wrapping past the last active subband moves L-STF -> L-LTF, or ends the packet.
                            if (sb_last) begin
                                sb_q    <= sb_first_q;
                                field_q <= 1'b1;
                                if (field_q) st <= DONE;
                            end else begin
                                sb_q <= sb_next;
                            end
                        end else begin
                            smp_q <= smp_q + SMP_W'(1);
                        end
                    end
                end
                DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    st       <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qcs_nhtp_rd_seq.sv
// Scoreboard bench for the NHTP read sequencer: expected reads are queued at stimulus
// time and popped by a monitor whenever the sequencer issues a table read.
module tb_qcs_nhtp_rd_seq;

    localparam int ADDR_DW   = 7;
    localparam int NUM_SMP   = 64;
    localparam int BW_W      = 2;
    localparam int SUBBAND_W = 8;
    localparam int GAMMA_W   = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    qcs_nhtp_rd_seq_if #(
        .ADDR_DW(ADDR_DW), .BW_W(BW_W), .SUBBAND_W(SUBBAND_W), .GAMMA_W(GAMMA_W)
    ) bus ();

    qcs_nhtp_rd_seq #(
        .ADDR_DW(ADDR_DW), .NUM_SMP(NUM_SMP), .BW_W(BW_W), .SUBBAND_W(SUBBAND_W), .GAMMA_W(GAMMA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int addr;
        int sb;
        int gamma;
    } rd_exp_t;

    typedef struct {
        logic [1:0]  bw;
        logic [1:0]  sys;
        logic [7:0]  pres;
        logic [3:0]  ntx;
    } err_case_t;

    rd_exp_t exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int n_reads = 0;
    int n_done = 0;
    int n_errp = 0;
    int first_re = -1;
    int done_cyc = -1;
    int err_cyc = -1;
    int t_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per issued read and tallies done/err pulses.
    always @(negedge clk) begin
        rd_exp_t e;
        if (!reset) begin
            if (bus.nhtp_re) begin
                n_reads++;
                if (first_re < 0) first_re = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_read", int'(bus.nhtp_raddr), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("raddr", int'(bus.nhtp_raddr), e.addr);
                    check("sb_idx", int'(bus.nhtp_sb_idx), e.sb);
                    check("gamma", int'(bus.nhtp_gamma), e.gamma);
                end
            end
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (bus.err) begin
                n_errp++;
                err_cyc = cyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input logic [1:0] bw, input logic [1:0] sys, input logic [7:0] pres,
                           input logic [15:0] gam, input logic [3:0] ntx);
        bus.txconfig_bw               = bw;
        bus.sys_bw_mode               = sys;
        bus.config_mu_subband_present = pres;
        bus.config_gamma_rotation     = gam;
        bus.n_tx                      = ntx;
    endtask

    // Reference walk: field outer, active subband middle, sample inner.
    task automatic push_pkt(input logic [1:0] bw, input logic [7:0] pres, input logic [15:0] gam);
        logic [7:0] span;
        logic [7:0] mask;
        span = 8'((1 << (1 << bw)) - 1);
        mask = pres & span;
        for (int f = 0; f < 2; f++)
            for (int sb = 0; sb < 8; sb++)
                if (mask[sb])
                    for (int s = 0; s < NUM_SMP; s++)
                        exp_q.push_back('{f * NUM_SMP + s, sb, int'(gam[2*sb +: 2])});
    endtask

    task automatic pulse_start();
        n_reads  = 0;
        first_re = -1;
        done_cyc = -1;
        err_cyc  = -1;
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        t_start   = cyc + 1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = n_done;
        for (int i = 0; i < budget && n_done == d0; i++) step(1);
        check({name, "_done_seen"}, n_done - d0, 1);
    endtask

    task automatic wait_reads(input string name, input int n);
        for (int i = 0; i < 2000 && n_reads < n; i++) step(1);
        check({name, "_reads_reached"}, n_reads, n);
    endtask

    initial begin
        err_case_t ecases[3];
        logic [ADDR_DW-1:0] addr_frz;
        int d0;
        int e0;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.rd_rdy = 1'b1;
        set_cfg(2'd0, 2'd0, 8'h00, 16'h0000, 4'd0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_re", int'(bus.nhtp_re), 0);
        check("rst_raddr", int'(bus.nhtp_raddr), 0);
        check("rst_sb_idx", int'(bus.nhtp_sb_idx), 0);
        check("rst_gamma", int'(bus.nhtp_gamma), 0);
        check("rst_n_tx", int'(bus.nhtp_n_tx), 0);
        check("rst_4ch", int'(bus.nhtp_4ch), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.err), 0);
        reset = 1'b0;

        // 20 MHz single subband
        set_cfg(2'd0, 2'd3, 8'h01, 16'h0002, 4'd2);
        push_pkt(2'd0, 8'h01, 16'h0002);
        pulse_start();
        check("t20_busy", int'(bus.busy), 1);
        wait_done("t20", 400);
        check("t20_first_re_lat", first_re - t_start, 2);
        check("t20_done_lat", done_cyc - t_start, 130);
        check("t20_reads", n_reads, 128);
        check("t20_q_empty", exp_q.size(), 0);
        check("t20_n_tx", int'(bus.nhtp_n_tx), 2);
        check("t20_4ch", int'(bus.nhtp_4ch), 0);
        check("t20_busy_after", int'(bus.busy), 0);

        // 80 MHz with subband 2 punctured
        set_cfg(2'd2, 2'd3, 8'h0B, 16'h00E4, 4'd4);
        push_pkt(2'd2, 8'h0B, 16'h00E4);
        pulse_start();
        step(1);
        check("t80_4ch", int'(bus.nhtp_4ch), 1);
        check("t80_n_tx", int'(bus.nhtp_n_tx), 4);
        wait_done("t80", 1000);
        check("t80_reads", n_reads, 384);
        check("t80_done_lat", done_cyc - t_start, 386);
        check("t80_q_empty", exp_q.size(), 0);

        // Backpressure: rd_rdy low for 5 cycles mid-subband
        set_cfg(2'd0, 2'd1, 8'h01, 16'h0002, 4'd1);
        push_pkt(2'd0, 8'h01, 16'h0002);
        pulse_start();
        wait_reads("stall", 20);
        addr_frz = bus.nhtp_raddr;
        bus.rd_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("stall_re_low", int'(bus.nhtp_re), 0);
        end
        check("stall_reads_held", n_reads, 20);
        check("stall_addr_frozen", int'(bus.nhtp_raddr), int'(addr_frz));
        bus.rd_rdy = 1'b1;
        wait_done("stall", 400);
        check("stall_reads", n_reads, 128);
        check("stall_done_lat", done_cyc - t_start, 135);
        check("stall_q_empty", exp_q.size(), 0);

        // Config errors: bw over system, empty mask, zero chains
        ecases[0] = '{2'd2, 2'd1, 8'hFF, 4'd1};
        ecases[1] = '{2'd0, 2'd3, 8'h00, 4'd1};
        ecases[2] = '{2'd0, 2'd3, 8'h01, 4'd0};
        foreach (ecases[k]) begin
            set_cfg(ecases[k].bw, ecases[k].sys, ecases[k].pres, 16'hFFFF, ecases[k].ntx);
            d0 = n_done;
            e0 = n_errp;
            pulse_start();
            step(4);
            check($sformatf("err%0d_lat", k), err_cyc - t_start, 1);
            check($sformatf("err%0d_pulses", k), n_errp - e0, 1);
            check($sformatf("err%0d_reads", k), n_reads, 0);
            check($sformatf("err%0d_no_done", k), n_done - d0, 0);
            check($sformatf("err%0d_busy", k), int'(bus.busy), 0);
        end

        // Abort after 40 reads, then a full packet
        set_cfg(2'd0, 2'd3, 8'h01, 16'h0002, 4'd3);
        push_pkt(2'd0, 8'h01, 16'h0002);
        pulse_start();
        wait_reads("abort", 40);
        bus.abort = 1'b1;
        exp_q.delete();
        d0 = n_done;
        e0 = n_errp;
        step(1);
        check("abort_re_low", int'(bus.nhtp_re), 0);
        check("abort_busy_low", int'(bus.busy), 0);
        bus.abort = 1'b0;
        step(4);
        check("abort_reads", n_reads, 40);
        check("abort_no_done", n_done - d0, 0);
        check("abort_no_err", n_errp - e0, 0);
        push_pkt(2'd0, 8'h01, 16'h0002);
        pulse_start();
        wait_done("post_abort", 400);
        check("post_abort_reads", n_reads, 128);
        check("post_abort_q_empty", exp_q.size(), 0);

        // Start during RUN with a different config is ignored
        set_cfg(2'd1, 2'd3, 8'h03, 16'h0009, 4'd6);
        push_pkt(2'd1, 8'h03, 16'h0009);
        pulse_start();
        wait_reads("restart", 10);
        set_cfg(2'd3, 2'd3, 8'hFF, 16'hFFFF, 4'd5);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        wait_done("restart", 800);
        check("restart_reads", n_reads, 256);
        check("restart_done_lat", done_cyc - t_start, 258);
        check("restart_n_tx", int'(bus.nhtp_n_tx), 6);
        check("restart_4ch", int'(bus.nhtp_4ch), 0);
        check("restart_q_empty", exp_q.size(), 0);

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
